audio_tone_gen: RTL and testbench
=================================

Name: audio_tone_gen

Overview:
- Parametrised multi-channel test-tone source for the HDMI audio path.
- Derives an audio-sample strobe from the pixel clock by integer division. Runs one phase accumulator per channel and produces signed samples with selectable waveform and attenuation.
- Feeds the hdmi audio_sample_word input.
- Replaces gated-clock audio strobes and fixed sawtooth generators with a single-clock, clock-enable design.

Parameters:
- DIVIDER, 1547, pixel clocks per audio sample (74.25 MHz / 1547 ≈ 48 kHz); must be ≥ 2.
- BIT_WIDTH, 16, sample width, signed two's complement.
- CHANNELS, 2, number of independent channels.
- PHASE_WIDTH, 24, phase accumulator width; must be ≥ BIT_WIDTH+1.
- ATTEN_WIDTH, 4, width of per-channel attenuation shift.

Ports:
- clk_pixel  input  1  system clock (pixel clock).
- reset  input  1  synchronous, active-high reset.
- tuning_word  input  CHANNELS*PHASE_WIDTH  per-channel phase increment; channel c occupies bits [c*PHASE_WIDTH +: PHASE_WIDTH].
- mode  input  CHANNELS*2  per-channel waveform: 0 silence, 1 sawtooth, 2 square, 3 triangle.
- atten  input  CHANNELS*ATTEN_WIDTH  per-channel arithmetic right-shift amount.
- enable  input  1  run/freeze for the whole block.
- audio_en  output  1  one-cycle sample strobe.
- sample_valid  output  1  one-cycle pulse: new samples present on audio_sample_word.
- audio_sample_word  output  CHANNELS*BIT_WIDTH  registered signed samples; channel c at [c*BIT_WIDTH +: BIT_WIDTH].

Behaviour:
- Single clock domain. No gated or derived clocks. All state updates on posedge clk_pixel.
- Reset, synchronous and dominant over all other activity:
  - divider counter = 0;
  - all phase accumulators = 0;
  - audio_en = 0, sample_valid = 0;
  - audio_sample_word = 0;
  - latched mode/atten/tuning registers = 0.
- Divider:
  - counter runs 0..DIVIDER-1 and wraps to 0 while enable = 1;
  - audio_en is registered and high for exactly one cycle, the cycle in which counter == DIVIDER-1; period is exactly DIVIDER cycles;
  - enable = 0 holds the counter and forces audio_en = 0; counting resumes from the held value when enable returns to 1.
- Pipeline, with the strobe cycle called N:
  - edge ending N: per-channel phase <= phase + tuning_word (mod 2^PHASE_WIDTH); mode and atten are latched at the same edge;
  - edge ending N+1: waveform value computed from the new phase, shifted by the latched atten, and registered into audio_sample_word; sample_valid <= 1;
  - sample_valid is high during cycle N+2 only; latency from audio_en to sample_valid = 2 cycles.
- audio_sample_word holds its value between sample_valid pulses.
- Input changes outside the strobe cycle are ignored until the next strobe. This guarantees glitch-free, sample-aligned mode changes.
- Waveform, with p = phase[PHASE_WIDTH-1 -: BIT_WIDTH] and W = BIT_WIDTH:
  - silence: 0;
  - sawtooth: p with the MSB inverted (p=0 → -2^(W-1); p=all-ones → 2^(W-1)-1);
  - square: p[W-1]=0 → +(2^(W-1)-1); otherwise -(2^(W-1)-1) (symmetric, never the most-negative code);
  - triangle: q = p[W-1] ? ~p[W-2:0] : p[W-2:0]; output = {q,1'b0} with the MSB inverted.
- Attenuation:
  - arithmetic (sign-preserving) right shift by atten;
  - a shift ≥ BIT_WIDTH-1 yields 0 or -1 according to sign.
- Phase wrap: natural modular overflow; no saturation.
- tuning_word = 0 gives a constant output at the current phase.
- Reset asserted mid-pipeline: any in-flight sample is discarded and no sample_valid is produced.
  - First audio_en after reset release occurs DIVIDER cycles after the first cycle with reset = 0 and enable = 1.
- Channels are fully independent. The same strobe updates all channels in the same cycle.

Test Plan:
1. DIVIDER=4, enable=1, release reset → audio_en high on cycles 4, 8, 12 after release; sample_valid exactly 2 cycles after each audio_en; no other pulses over 100 cycles.
2. Sawtooth, ch0: PHASE_WIDTH=24, W=16, tuning=0x100000, atten=0 → successive samples 0x9000, 0xA000, … 0xF000, 0x0000, … 0x7000, then 0x8000; exact wrap every 16 samples.
3. Triangle ch0 and square ch1, same tuning: ch0 → 0xA000, 0xC000, 0xE000, 0x0000, … rising to 0x7FFE then falling; ch1 → 0x7FFF for 7 samples, then 0x8001 for 8, period 16. Channels independent in packed bus.
4. Attenuation: sawtooth, atten=9 → every output equals the unattenuated value arithmetically shifted right by 9 (0x9000 → 0xFFC8); atten changed mid-period takes effect only on the sample after the next audio_en.
5. enable dropped for 10 cycles mid-count → audio_en suppressed, counter holds, phase frozen; sample sequence resumes with no skipped or repeated value.
6. reset asserted 1 cycle after audio_en → no sample_valid follows; all outputs 0 on the next cycle; first post-reset sample equals the first sample from a cold start (0x9000 for test 2 settings).

Source files
------------

// File: rtl/audio_tone_gen.sv
// Multi-channel test-tone source: pixel-clock divider strobe, per-channel phase
// accumulators, and a two-stage waveform/attenuation pipeline into a packed bus.
module audio_tone_gen #(
    parameter int DIVIDER     = 1547,
    parameter int BIT_WIDTH   = 16,
    parameter int CHANNELS    = 2,
    parameter int PHASE_WIDTH = 24,
    parameter int ATTEN_WIDTH = 4
) (
    input  logic                             clk_pixel,
    input  logic                             reset,
    input  logic [CHANNELS*PHASE_WIDTH-1:0]  tuning_word,
    input  logic [CHANNELS*2-1:0]            mode,
    input  logic [CHANNELS*ATTEN_WIDTH-1:0]  atten,
    input  logic                             enable,
    output logic                             audio_en,
    output logic                             sample_valid,
    output logic [CHANNELS*BIT_WIDTH-1:0]    audio_sample_word
);

    localparam int CW = (DIVIDER > 2) ? $clog2(DIVIDER) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

    typedef enum logic [1:0] {
        WAVE_SILENCE = 2'd0,
        WAVE_SAW     = 2'd1,
        WAVE_SQUARE  = 2'd2,
        WAVE_TRI     = 2'd3
    } wave_t;

    logic [CW-1:0]                 counter;
    logic                          strobe_d;
    logic [PHASE_WIDTH-1:0]        phase   [CHANNELS];
    wave_t                         mode_q  [CHANNELS];
    logic [ATTEN_WIDTH-1:0]        atten_q [CHANNELS];
    logic signed [BIT_WIDTH-1:0]   shaped  [CHANNELS];

    function automatic logic signed [BIT_WIDTH-1:0] shape(wave_t m, logic [BIT_WIDTH-1:0] p);
        logic [BIT_WIDTH-2:0] q;
        logic [BIT_WIDTH-1:0] v;
        q = p[BIT_WIDTH-1] ? ~p[BIT_WIDTH-2:0] : p[BIT_WIDTH-2:0];
        case (m)
            WAVE_SAW:    v = {~p[BIT_WIDTH-1], p[BIT_WIDTH-2:0]};
            WAVE_SQUARE: v = p[BIT_WIDTH-1] ? {1'b1, {(BIT_WIDTH-2){1'b0}}, 1'b1}
                                            : {1'b0, {(BIT_WIDTH-1){1'b1}}};
            WAVE_TRI:    v = {~q[BIT_WIDTH-2], q[BIT_WIDTH-3:0], 1'b0};
            default:     v = '0;
        endcase
        return v;
    endfunction

    // Shifts of W-1 or more collapse to the sign: 0 for positive, -1 for negative.
    function automatic logic signed [BIT_WIDTH-1:0] attenuate(logic signed [BIT_WIDTH-1:0] v,
                                                               logic [ATTEN_WIDTH-1:0] a);
        if (int'(a) >= BIT_WIDTH - 1)
            return v[BIT_WIDTH-1] ? '1 : '0;
        return v >>> a;
    endfunction

    always_comb begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            shaped[c] = attenuate(shape(mode_q[c], phase[c][PHASE_WIDTH-1 -: BIT_WIDTH]), atten_q[c]);
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            counter           <= '0;
            audio_en          <= 1'b0;
            strobe_d          <= 1'b0;
            sample_valid      <= 1'b0;
            audio_sample_word <= '0;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                phase[c]   <= '0;
                mode_q[c]  <= WAVE_SILENCE;
                atten_q[c] <= '0;
            end
        end else begin
            if (enable)
                counter <= (counter == LAST) ? '0 : counter + CW'(1);
            audio_en     <= enable && (counter == LAST);
            strobe_d     <= audio_en;
            sample_valid <= strobe_d;

            // Inputs are sampled only at the strobe so mode changes stay sample-aligned.
            if (audio_en) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    phase[c]   <= phase[c] + tuning_word[c*PHASE_WIDTH +: PHASE_WIDTH];
                    mode_q[c]  <= wave_t'(mode[c*2 +: 2]);
                    atten_q[c] <= atten[c*ATTEN_WIDTH +: ATTEN_WIDTH];
                end
            end

            if (strobe_d) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    audio_sample_word[c*BIT_WIDTH +: BIT_WIDTH] <= shaped[c];
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_tone_gen.sv
// Directed bench for audio_tone_gen with DIVIDER=4, two 16-bit channels and
// 24-bit phase; expected samples are hand-computed tables.
module tb_audio_tone_gen;

    logic        clk_pixel = 1'b0;
    logic        reset     = 1'b1;
    logic [47:0] tuning_word = '0;
    logic [3:0]  mode  = '0;
    logic [7:0]  atten = '0;
    logic        enable = 1'b1;
    logic        audio_en;
    logic        sample_valid;
    logic [31:0] audio_sample_word;

    int checks = 0;
    int errors = 0;
    int n;

    logic [15:0] saw_t [16] = '{16'h9000, 16'hA000, 16'hB000, 16'hC000, 16'hD000, 16'hE000,
                                16'hF000, 16'h0000, 16'h1000, 16'h2000, 16'h3000, 16'h4000,
                                16'h5000, 16'h6000, 16'h7000, 16'h8000};
    logic [15:0] tri_t [16] = '{16'hA000, 16'hC000, 16'hE000, 16'h0000, 16'h2000, 16'h4000,
                                16'h6000, 16'h7FFE, 16'h5FFE, 16'h3FFE, 16'h1FFE, 16'hFFFE,
                                16'hDFFE, 16'hBFFE, 16'h9FFE, 16'h8000};
    logic [15:0] sq_t  [16] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                16'h7FFF, 16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h8001,
                                16'h8001, 16'h8001, 16'h8001, 16'h7FFF};

    audio_tone_gen #(
        .DIVIDER     (4),
        .BIT_WIDTH   (16),
        .CHANNELS    (2),
        .PHASE_WIDTH (24),
        .ATTEN_WIDTH (4)
    ) dut (
        .clk_pixel         (clk_pixel),
        .reset             (reset),
        .tuning_word       (tuning_word),
        .mode              (mode),
        .atten             (atten),
        .enable            (enable),
        .audio_en          (audio_en),
        .sample_valid      (sample_valid),
        .audio_sample_word (audio_sample_word)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_pixel);
        #1;
    endtask

    // Leaves the bench in cycle 0: first cycle with reset low, counter at 0.
    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        check("reset_outputs", {audio_en, sample_valid, audio_sample_word}, 34'h0);
        reset = 1'b0;
    endtask

    task automatic wait_sample(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!sample_valid && cycles < 20);
        check("sample_valid_timeout", {31'h0, sample_valid}, 32'h1);
    endtask

    task automatic wait_strobe();
        int k = 0;
        do begin
            step();
            k++;
        end while (!audio_en && k < 20);
        check("audio_en_timeout", {31'h0, audio_en}, 32'h1);
    endtask

    initial begin
        // Test 1: strobe and valid timing over 100 cycles.
        mode        = 4'b00_01;
        tuning_word = {24'h0, 24'h100000};
        atten       = '0;
        enable      = 1'b1;
        do_reset();
        for (int i = 1; i <= 100; i++) begin
            step();
            check($sformatf("t1_pulses_c%0d", i), {30'h0, audio_en, sample_valid},
                  {30'h0, (i % 4 == 0), (i >= 6 && i % 4 == 2)});
        end

        // Test 2: sawtooth ch0, silence ch1, full wrap plus one.
        do_reset();
        wait_sample(n);
        check("t2_first_latency", n, 6);
        check("t2_saw_0", audio_sample_word, {16'h0000, saw_t[0]});
        for (int k = 1; k < 17; k++) begin
            wait_sample(n);
            check($sformatf("t2_period_%0d", k), n, 4);
            check($sformatf("t2_saw_%0d", k), audio_sample_word, {16'h0000, saw_t[k % 16]});
        end

        // Test 3: triangle ch0, square ch1 on the same tuning.
        mode        = 4'b10_11;
        tuning_word = {24'h100000, 24'h100000};
        do_reset();
        for (int k = 0; k < 17; k++) begin
            wait_sample(n);
            check($sformatf("t3_tri_sq_%0d", k), audio_sample_word, {sq_t[k % 16], tri_t[k % 16]});
        end

        // Test 4: attenuation and strobe-aligned atten changes.
        mode        = 4'b00_01;
        tuning_word = {24'h0, 24'h100000};
        atten       = 8'h09;
        do_reset();
        wait_sample(n); check("t4_att9_0", audio_sample_word, 32'h0000FFC8);
        wait_sample(n); check("t4_att9_1", audio_sample_word, 32'h0000FFD0);
        wait_sample(n); check("t4_att9_2", audio_sample_word, 32'h0000FFD8);
        wait_sample(n); check("t4_att9_3", audio_sample_word, 32'h0000FFE0);
        wait_strobe();
        step();
        atten = 8'h00;
        wait_sample(n); check("t4_att_held", audio_sample_word, 32'h0000FFE8);
        wait_sample(n); check("t4_att0", audio_sample_word, 32'h0000E000);
        atten = 8'h0F;
        wait_sample(n); check("t4_att15_neg", audio_sample_word, 32'h0000FFFF);
        wait_sample(n); check("t4_att15_zero", audio_sample_word, 32'h00000000);
        wait_sample(n); check("t4_att15_pos", audio_sample_word, 32'h00000000);

        // Test 5: enable low for 10 cycles freezes counter and phase.
        atten = 8'h00;
        do_reset();
        wait_sample(n); check("t5_before", audio_sample_word, 32'h00009000);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t5_frozen_%0d", i), {30'h0, audio_en, sample_valid}, 32'h0);
        end
        enable = 1'b1;
        wait_sample(n);
        check("t5_resume_latency", n, 4);
        check("t5_resume_value", audio_sample_word, 32'h0000A000);
        wait_sample(n); check("t5_next_value", audio_sample_word, 32'h0000B000);

        // Test 6: reset one cycle after a strobe discards the in-flight sample.
        do_reset();
        wait_sample(n); check("t6_pre", audio_sample_word, 32'h00009000);
        wait_strobe();
        step();
        reset = 1'b1;
        step();
        check("t6_cleared", {audio_en, sample_valid, audio_sample_word}, 34'h0);
        reset = 1'b0;
        wait_sample(n);
        check("t6_restart_latency", n, 6);
        check("t6_restart_value", audio_sample_word, 32'h00009000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
